// File: rtl/gmii_frame_read.sv
// Read side of the GMII receive FIFO: rebuilds frames from the flag bit, strips
// preamble/SFD, checks length and forwards a delimited payload byte stream.
module gmii_frame_read #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522,
   parameter int CNT_W   = 16
) (
   input  logic             clk_gmii_rx,
   input  logic             reset_n,
   input  logic [8:0]       iv_data,
   input  logic             i_data_empty,
   output logic             o_data_rd,
   input  logic             i_out_full,
   output logic [7:0]       ov_data,
   output logic             o_data_wr,
   output logic             o_head,
   output logic             o_tail,
   output logic             o_err,
   output logic [11:0]      ov_len,
   output logic [CNT_W-1:0] ov_drop_cnt,
   output logic [CNT_W-1:0] ov_stray_cnt,
   output logic [CNT_W-1:0] ov_err_cnt
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DISCARD} state_t;

   localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
   localparam logic [7:0]  PRE_B   = 8'h55;
   localparam logic [7:0]  SFD_B   = 8'hD5;

   state_t           state_q, state_d;
   logic             rd_vld_q;
   logic [2:0]       pre_cnt_q, pre_cnt_d;
   logic             first_q, first_d;
   logic [11:0]      len_q, len_d;
   logic [7:0]       data_q, data_d;
   logic             wr_q, wr_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             err_q, err_d;
   logic [11:0]      len_out_q, len_out_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] stray_q, stray_d;
   logic [CNT_W-1:0] errc_q, errc_d;

   logic             flag;
   logic [7:0]       byte_v;
   logic [11:0]      len_inc;
   logic             len_bad;

   // Reads are held off while reset is asserted so no word is popped and lost.
   assign o_data_rd = reset_n && !i_data_empty && !i_out_full;

   assign flag    = iv_data[8];
   assign byte_v  = iv_data[7:0];
   assign len_inc = (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
   assign len_bad = (len_inc < MIN_L) || (len_inc > MAX_L);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      first_d   = first_q;
      len_d     = len_q;
      data_d    = data_q;
      wr_d      = 1'b0;
      head_d    = 1'b0;
      tail_d    = 1'b0;
      err_d     = 1'b0;
      len_out_d = len_out_q;
      drop_d    = drop_q;
      stray_d   = stray_q;
      errc_d    = errc_q;
      if (rd_vld_q) begin
         case (state_q)
            IDLE: begin
               if (flag && byte_v == PRE_B) begin
                  state_d   = PRE;
                  pre_cnt_d = 3'd1;
               end else if (flag) begin
                  stray_d = stray_q + CNT_W'(1);
               end
            end
            PRE: begin
               if (flag) begin
                  drop_d  = drop_q + CNT_W'(1);
                  state_d = IDLE;
               end else if (byte_v == PRE_B && pre_cnt_q != 3'd7) begin
                  pre_cnt_d = pre_cnt_q + 3'd1;
               end else if (byte_v == SFD_B) begin
                  state_d = DATA;
                  first_d = 1'b1;
                  len_d   = 12'd0;
               end else begin
                  state_d = DISCARD;
               end
            end
            DATA: begin
               wr_d    = 1'b1;
               data_d  = byte_v;
               head_d  = first_q;
               first_d = 1'b0;
               len_d   = len_inc;
               if (flag) begin
                  tail_d    = 1'b1;
                  len_out_d = len_inc;
                  err_d     = len_bad;
                  if (len_bad) errc_d = errc_q + CNT_W'(1);
                  state_d   = IDLE;
               end
            end
            DISCARD: begin
               if (flag) begin
                  drop_d  = drop_q + CNT_W'(1);
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_gmii_rx or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rd_vld_q  <= 1'b0;
         pre_cnt_q <= 3'd0;
         first_q   <= 1'b0;
         len_q     <= 12'd0;
         data_q    <= 8'd0;
         wr_q      <= 1'b0;
         head_q    <= 1'b0;
         tail_q    <= 1'b0;
         err_q     <= 1'b0;
         len_out_q <= 12'd0;
         drop_q    <= '0;
         stray_q   <= '0;
         errc_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_vld_q  <= o_data_rd;
         pre_cnt_q <= pre_cnt_d;
         first_q   <= first_d;
         len_q     <= len_d;
         data_q    <= data_d;
         wr_q      <= wr_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         err_q     <= err_d;
         len_out_q <= len_out_d;
         drop_q    <= drop_d;
         stray_q   <= stray_d;
         errc_q    <= errc_d;
      end
   end

   assign ov_data      = data_q;
   assign o_data_wr    = wr_q;
   assign o_head       = head_q;
   assign o_tail       = tail_q;
   assign o_err        = err_q;
   assign ov_len       = len_out_q;
   assign ov_drop_cnt  = drop_q;
   assign ov_stray_cnt = stray_q;
   assign ov_err_cnt   = errc_q;

endmodule

// File: tb/tb_gmii_frame_read.sv
// Directed + randomized bench for gmii_frame_read: a queue models the FIFO and
// each generated frame predicts its own output beats and counter effects.
module tb_gmii_frame_read;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1522;
   localparam int CNT_W   = 16;

   logic             clk_gmii_rx = 1'b0;
   logic             reset_n;
   logic [8:0]       iv_data;
   logic             i_data_empty;
   logic             o_data_rd;
   logic             i_out_full;
   logic [7:0]       ov_data;
   logic             o_data_wr;
   logic             o_head;
   logic             o_tail;
   logic             o_err;
   logic [11:0]      ov_len;
   logic [CNT_W-1:0] ov_drop_cnt;
   logic [CNT_W-1:0] ov_stray_cnt;
   logic [CNT_W-1:0] ov_err_cnt;

   always #5 clk_gmii_rx = ~clk_gmii_rx;

   gmii_frame_read #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk_gmii_rx  (clk_gmii_rx),
      .reset_n      (reset_n),
      .iv_data      (iv_data),
      .i_data_empty (i_data_empty),
      .o_data_rd    (o_data_rd),
      .i_out_full   (i_out_full),
      .ov_data      (ov_data),
      .o_data_wr    (o_data_wr),
      .o_head       (o_head),
      .o_tail       (o_tail),
      .o_err        (o_err),
      .ov_len       (ov_len),
      .ov_drop_cnt  (ov_drop_cnt),
      .ov_stray_cnt (ov_stray_cnt),
      .ov_err_cnt   (ov_err_cnt)
   );

   typedef struct {logic [8:0] w; bit mark;} word_t;
   typedef struct {logic [7:0] d; bit head; bit tail; bit err; int len;} beat_t;

   word_t fifo_q[$];
   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    rd_cyc  = 0;
   bit    lat_pend = 1'b0;
   int    full_period = 0;
   int    out_cnt = 0;
   int    e_drop = 0, e_stray = 0, e_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_w(input logic [8:0] w, input bit mark);
      word_t e;
      e.w    = w;
      e.mark = mark;
      fifo_q.push_back(e);
   endtask

   // Frame = flagged 0x55, (n55-1) x 0x55, sfd, plen payload bytes (last flagged).
   task automatic push_frame(input int n55, input logic [7:0] sfd, input int plen, input bit incr);
      bit    good;
      beat_t b;
      logic [7:0] d;
      good = (n55 >= 1) && (n55 <= 7) && (sfd == 8'hD5);
      push_w({1'b1, 8'h55}, 1'b0);
      for (int i = 1; i < n55; i++) push_w({1'b0, 8'h55}, 1'b0);
      push_w({1'b0, sfd}, 1'b0);
      for (int i = 0; i < plen; i++) begin
         d = incr ? 8'(i) : 8'($urandom);
         push_w({(i == plen - 1), d}, good && (i == 0));
         if (good) begin
            b.d    = d;
            b.head = (i == 0);
            b.tail = (i == plen - 1);
            b.len  = (plen > 4095) ? 4095 : plen;
            b.err  = (plen < MIN_LEN) || (plen > MAX_LEN);
            exp_q.push_back(b);
         end
      end
      if (!good) e_drop++;
      else if ((plen < MIN_LEN) || (plen > MAX_LEN)) e_err++;
   endtask

   // One clock: FIFO pop model, output monitor, and input updates on the falling edge.
   task automatic step();
      bit    rd_now;
      int    rd_c;
      word_t e;
      beat_t b;
      @(posedge clk_gmii_rx);
      rd_now = o_data_rd;
      rd_c   = cyc;
      cyc++;
      @(negedge clk_gmii_rx);
      check("o_data_rd", 32'(o_data_rd), 32'(reset_n && !i_data_empty && !i_out_full));
      if (rd_now && fifo_q.size() != 0) begin
         e = fifo_q.pop_front();
         iv_data = e.w;
         if (e.mark) begin
            rd_cyc   = rd_c;
            lat_pend = 1'b1;
         end
      end
      if (reset_n && o_data_wr) begin
         if (exp_q.size() == 0) begin
            check("spurious_wr", 32'(o_data_wr), 32'd0);
         end else begin
            b = exp_q.pop_front();
            out_cnt++;
            check("ov_data", 32'(ov_data), 32'(b.d));
            check("o_head", 32'(o_head), 32'(b.head));
            check("o_tail", 32'(o_tail), 32'(b.tail));
            if (b.tail) begin
               check("o_err", 32'(o_err), 32'(b.err));
               check("ov_len", 32'(ov_len), 32'(b.len));
            end
         end
         if (lat_pend) begin
            check("first_latency", 32'(cyc - rd_cyc), 32'd2);
            lat_pend = 1'b0;
         end
      end
      if (full_period > 0) begin
         if (cyc % full_period == 0) i_out_full = !i_out_full;
      end else begin
         i_out_full = 1'b0;
      end
      i_data_empty = (fifo_q.size() == 0);
   endtask

   task automatic check_cnt();
      check("drop_cnt", 32'(ov_drop_cnt), 32'(e_drop[CNT_W-1:0]));
      check("stray_cnt", 32'(ov_stray_cnt), 32'(e_stray[CNT_W-1:0]));
      check("err_cnt", 32'(ov_err_cnt), 32'(e_err[CNT_W-1:0]));
   endtask

   task automatic drain();
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
         step();
         n++;
      end
      repeat (4) step();
      check("drain_beats_left", 32'(exp_q.size()), 32'd0);
      check_cnt();
   endtask

   task automatic check_idle_outputs();
      check("rst_o_data_wr", 32'(o_data_wr), 32'd0);
      check("rst_ov_data", 32'(ov_data), 32'd0);
      check("rst_o_head", 32'(o_head), 32'd0);
      check("rst_o_tail", 32'(o_tail), 32'd0);
      check("rst_o_err", 32'(o_err), 32'd0);
      check("rst_ov_len", 32'(ov_len), 32'd0);
      check("rst_o_data_rd", 32'(o_data_rd), 32'd0);
      check_cnt();
   endtask

   initial begin
      int start;
      int n;
      reset_n      = 1'b0;
      iv_data      = 9'd0;
      i_data_empty = 1'b1;
      i_out_full   = 1'b0;
      repeat (3) step();
      check_idle_outputs();
      reset_n = 1'b1;
      repeat (2) step();

      // good 64-byte frame with incrementing payload
      push_frame(7, 8'hD5, 64, 1'b1);
      drain();

      // runt
      push_frame(7, 8'hD5, 10, 1'b0);
      drain();

      // lone overflow marker, then a good frame
      push_w({1'b1, 8'h00}, 1'b0);
      e_stray++;
      push_frame(7, 8'hD5, 64, 1'b0);
      drain();

      // bad SFD
      push_frame(2, 8'hAA, 20, 1'b0);
      drain();

      // early tail inside preamble, then unflagged junk in IDLE
      push_w({1'b1, 8'h55}, 1'b0);
      push_w({1'b0, 8'h55}, 1'b0);
      push_w({1'b1, 8'h12}, 1'b0);
      e_drop++;
      for (int i = 0; i < 5; i++) push_w({1'b0, 8'($urandom)}, 1'b0);
      drain();

      // over-long preamble
      push_frame(8, 8'hD5, 30, 1'b0);
      drain();

      // length boundaries, single-byte payload, and length saturation
      push_frame(7, 8'hD5, 63, 1'b0);
      push_frame(1, 8'hD5, 1, 1'b0);
      push_frame(7, 8'hD5, 1522, 1'b0);
      push_frame(7, 8'hD5, 1523, 1'b0);
      drain();
      push_frame(7, 8'hD5, 4100, 1'b0);
      drain();

      // backpressure toggling every 3 cycles
      full_period = 3;
      push_frame(7, 8'hD5, 100, 1'b0);
      drain();

      // randomized batches
      for (int k = 0; k < 4; k++) begin
         full_period = int'($urandom_range(0, 5));
         for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 4) == 0) begin
               push_frame(int'($urandom_range(1, 7)), 8'hAA, int'($urandom_range(1, 80)), 1'b0);
            end else begin
               push_frame(int'($urandom_range(1, 7)), 8'hD5, int'($urandom_range(1, 150)), 1'b0);
            end
            if ($urandom_range(0, 3) == 0) begin
               push_w({1'b1, 8'h00}, 1'b0);
               e_stray++;
            end
         end
         drain();
      end
      full_period = 0;
      repeat (2) step();

      // reset after payload byte 30 of 64
      start = out_cnt;
      push_frame(7, 8'hD5, 64, 1'b1);
      n = 0;
      while (out_cnt < start + 30 && n < 2000) begin
         step();
         n++;
      end
      check("reset_wait_bytes", 32'(out_cnt - start >= 30), 32'd1);
      reset_n = 1'b0;
      exp_q.delete();
      lat_pend = 1'b0;
      e_drop   = 0;
      e_stray  = 0;
      e_err    = 0;
      repeat (2) step();
      check_idle_outputs();
      reset_n = 1'b1;
      e_stray = 1;
      push_frame(7, 8'hD5, 64, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gmii_frame_read.md
Name: gmii_frame_read

Overview:
- Read side of the 9-bit receive FIFO filled by the GMII write block. Pops {flag, byte} words and rebuilds frame boundaries from the flag bit (first flagged word = head, next flagged word = tail).
- Strips preamble/SFD, checks length, and forwards a delimited payload byte stream with head/tail/error markers to the network input pipeline.
- Counts dropped, stray and errored frames. Runs entirely in the GMII receive clock domain.

Parameters:
- MIN_LEN, 64, minimum legal payload length in bytes (DA through FCS).
- MAX_LEN, 1522, maximum legal payload length in bytes.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_gmii_rx  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- iv_data  in  9  FIFO read data; bit8 = frame flag, bits7:0 = byte; valid 1 cycle after o_data_rd.
- i_data_empty  in  1  FIFO empty.
- o_data_rd  out  1  FIFO read strobe.
- i_out_full  in  1  downstream almost-full; asserted with at least 2 free slots remaining.
- ov_data  out  8  payload byte.
- o_data_wr  out  1  ov_data valid.
- o_head  out  1  first payload byte (qualified by o_data_wr).
- o_tail  out  1  last payload byte (qualified by o_data_wr).
- o_err  out  1  frame bad; valid with o_tail.
- ov_len  out  12  payload length; valid with o_tail.
- ov_drop_cnt  out  CNT_W  frames discarded without output.
- ov_stray_cnt  out  CNT_W  stray flagged words discarded in IDLE.
- ov_err_cnt  out  CNT_W  frames forwarded with o_err=1.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE, internal read-valid pipe 0.

- Read and latency:
  - o_data_rd = !i_data_empty && !i_out_full (combinational).
  - rd_vld is o_data_rd delayed 1 cycle; iv_data is processed when rd_vld=1.
  - Outputs are registered, so a byte read at cycle N appears at cycle N+2.
  - The 2-slot headroom on i_out_full absorbs in-flight words; no skid buffer.

- IDLE:
  - Flagged word with byte 0x55 -> PRE, preamble count = 1.
  - Flagged word with any other byte (e.g. the writer's {1,0x00} overflow marker) -> stray; ov_stray_cnt+1; stay in IDLE.
  - Unflagged word -> dropped silently (resync after reset/overflow); stay in IDLE.

- PRE:
  - Unflagged 0x55 with count < 7 -> count+1.
  - Unflagged 0xD5 -> DATA, first-byte pending set, length = 0.
  - Any other byte, or 0x55 with count = 7 -> DISCARD.
  - Flagged word (early tail) -> ov_drop_cnt+1 -> IDLE.

- DATA:
  - Each word is output with o_data_wr=1; o_head=1 on the first byte.
  - Length increments and saturates at 4095.
  - Flagged word -> that byte is output with o_tail=1, ov_len = final length (including the tail byte).
  - o_err = (len < MIN_LEN) || (len > MAX_LEN). If o_err, ov_err_cnt+1. Then -> IDLE.
  - A single-byte payload gives o_head=o_tail=1 on the same beat, with o_err=1.

- DISCARD:
  - Consume words with no output.
  - On a flagged word: ov_drop_cnt+1 -> IDLE.

- Counters wrap modulo 2^CNT_W. If i_out_full and i_data_empty change together, only o_data_rd gates reads; no state change without rd_vld.

- Reset asserted mid-frame: immediate return to IDLE with outputs cleared. The remainder of the interrupted frame is absorbed by the IDLE rules (unflagged words dropped; its tail counted as stray).

Test Plan:
- Good frame: head 0x55, 6x 0x55, 0xD5, 64 bytes 0x00..0x3F with the last flagged -> 64 writes, o_head on 0x00, o_tail on 0x3F, ov_len=64, o_err=0, first output 2 cycles after the first payload read.
- Runt: preamble+SFD+10 bytes -> 10 writes, o_tail with ov_len=10, o_err=1, ov_err_cnt=1.
- Stray marker: lone {1,0x00}, then a good frame -> ov_stray_cnt=1; the good frame is forwarded intact.
- Bad SFD: head 0x55, 0x55, 0xAA, 20 bytes, flagged tail -> no o_data_wr, ov_drop_cnt=1.
- Backpressure: toggle i_out_full every 3 cycles during a 100-byte frame -> o_data_rd=0 whenever full, all 100 bytes output in order, no loss or duplication.
- Reset at payload byte 30 of 64, release, send a fresh frame -> outputs 0 during reset, leftover frame bytes dropped, ov_stray_cnt=1 (old tail), new frame forwarded correctly.
